// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: byte-serial fetch of 16-bit instructions (low byte at PC, high at PC+1) with valid/ack handoff
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int MEM_LATENCY = 1
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Start,
  input  logic        PcLoad,
  input  logic [15:0] PcLoadValue,
  input  logic        IrAck,
  input  logic [7:0]  MemData,
  output logic        MemRead,
  output logic [15:0] MemAddr,
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic        IrValid
);
  typedef enum logic [2:0] {IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, HOLD} state_t;
  state_t state;
  logic [2:0] cnt;
  logic [15:0] pc_inc;
  logic done;
  assign pc_inc = PC + 16'd1;
  assign done = (cnt + 3'd1) == 3'(MEM_LATENCY);
  // MemRead/MemAddr are registered on entry to the request states
  always_ff @(posedge Clock or negedge ResetN)
    if (!ResetN) begin
      state   <= IDLE;
      cnt     <= '0;
      PC      <= RESET_PC;
      IR      <= '0;
      IrValid <= 1'b0;
      MemRead <= 1'b0;
      MemAddr <= '0;
    end else if (PcLoad) begin
      state   <= IDLE;
      PC      <= PcLoadValue;
      IrValid <= 1'b0;
      MemRead <= 1'b0;
    end else
      case (state)
        IDLE:
          if (Start) begin
            state   <= REQ_LO;
            MemRead <= 1'b1;
            MemAddr <= PC;
          end
        REQ_LO: begin
          state   <= WAIT_LO;
          MemRead <= 1'b0;
          cnt     <= '0;
        end
        WAIT_LO: begin
          cnt <= cnt + 3'd1;
          if (done) begin
            state   <= REQ_HI;
            IR[7:0] <= MemData;
            PC      <= pc_inc;
            MemRead <= 1'b1;
            MemAddr <= pc_inc;
          end
        end
        REQ_HI: begin
          state   <= WAIT_HI;
          MemRead <= 1'b0;
          cnt     <= '0;
        end
        WAIT_HI: begin
          cnt <= cnt + 3'd1;
          if (done) begin
            state    <= HOLD;
            IR[15:8] <= MemData;
            PC       <= pc_inc;
            IrValid  <= 1'b1;
          end
        end
        HOLD:
          if (IrAck) begin
            IrValid <= 1'b0;
            state   <= Start ? REQ_LO : IDLE;
            MemRead <= Start;
            MemAddr <= PC;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vectors, corner sequences and a transaction-level random model
module tb_instr_fetch_unit;
  localparam int L1 = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0, pcl = 1'b0, ack = 1'b0, start3 = 1'b0;
  logic [15:0] pcv = '0;
  logic rd, valid, rd3, valid3;
  logic [15:0] addr, ir, pc, addr3, ir3, pc3;
  logic [7:0] md, md3;
  logic [7:0] mem [0:65535];
  logic p1v = 1'b0;
  logic [15:0] p1a = '0;
  logic [2:0] p3v = '0;
  logic [15:0] p3a [3];
  int checks = 0, failures = 0;
  instr_fetch_unit #(.RESET_PC(16'h0000), .MEM_LATENCY(1)) dut (
    .Clock(clk), .ResetN(rst_n), .Start(start), .PcLoad(pcl), .PcLoadValue(pcv),
    .IrAck(ack), .MemData(md), .MemRead(rd), .MemAddr(addr), .IR(ir), .PC(pc), .IrValid(valid));
  instr_fetch_unit #(.RESET_PC(16'h0000), .MEM_LATENCY(3)) dut3 (
    .Clock(clk), .ResetN(rst_n), .Start(start3), .PcLoad(pcl), .PcLoadValue(pcv),
    .IrAck(ack), .MemData(md3), .MemRead(rd3), .MemAddr(addr3), .IR(ir3), .PC(pc3), .IrValid(valid3));
  // memory returns data exactly MEM_LATENCY cycles after the read strobe, garbage otherwise
  always @(posedge clk) begin
    p1v <= rd;
    p1a <= addr;
    p3v <= {p3v[1:0], rd3};
    p3a[0] <= addr3;
    p3a[1] <= p3a[0];
    p3a[2] <= p3a[1];
  end
  assign md  = p1v ? mem[p1a] : 8'hEE;
  assign md3 = p3v[2] ? mem[p3a[2]] : 8'hEE;

  typedef struct {
    logic start, ack, pcl;
    logic [15:0] pcv;
    logic rd;
    logic [15:0] addr, pc;
    logic valid;
    logic [15:0] ir;
  } vec_t;
  vec_t tv [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] m_pc, m_ir;
  logic m_valid, m_busy;
  int m_t;

  initial begin
    int rise, nrd;
    mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'hCD; mem[3] = 8'hAB;
    mem[4] = 8'h11; mem[5] = 8'h22;
    tick; tick;
    rst_n = 1'b1;
    // run a full fetch, then reset asynchronously mid-cycle
    start = 1'b1;
    tick; start = 1'b0;
    tick; tick; tick; tick;
    chk("pre_reset_valid", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 16'h0000);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_valid", valid, 0);
    chk("rst_rd", rd, 0);
    chk("rst_addr", addr, 16'h0000);
    tick;
    rst_n = 1'b1;
    // MEM_LATENCY=3 instance, start edge is edge 0
    rise = -1; nrd = 0;
    start3 = 1'b1;
    tick;
    start3 = 1'b0;
    if (rd3) nrd++;
    for (int e = 1; e <= 20 && rise < 0; e++) begin
      tick;
      if (rd3) nrd++;
      if (valid3) rise = e;
    end
    chk("lat3_rise_edge", rise, 8);
    chk("lat3_rd_cycles", nrd, 2);
    chk("lat3_ir", ir3, 16'h1234);
    chk("lat3_pc", pc3, 16'h0002);
    tv = '{
      '{1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0000,16'h0000, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0000, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0001,16'h0001, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0001, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0002, 1'b1,16'h1234},
      '{1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0002, 1'b1,16'h1234},
      '{1'b1,1'b1,1'b0,16'h0000, 1'b1,16'h0002,16'h0002, 1'b0,16'h0000},
      '{1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0002, 1'b0,16'h0000},
      '{1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0003,16'h0003, 1'b0,16'h0000},
      '{1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0003, 1'b0,16'h0000},
      '{1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0004, 1'b1,16'hABCD},
      '{1'b1,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0004, 1'b1,16'hABCD},
      '{1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0000,16'h0004, 1'b0,16'h0000},
      '{1'b0,1'b1,1'b0,16'h0000, 1'b0,16'h0000,16'h0004, 1'b0,16'h0000},
      '{1'b1,1'b0,1'b0,16'h0000, 1'b1,16'h0004,16'h0004, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0004, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b1,16'h0005,16'h0005, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0005, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0006, 1'b1,16'h2211},
      '{1'b1,1'b1,1'b1,16'h0200, 1'b0,16'h0000,16'h0200, 1'b0,16'h0000},
      '{1'b0,1'b0,1'b0,16'h0000, 1'b0,16'h0000,16'h0200, 1'b0,16'h0000}
    };
    for (int i = 0; i < 21; i++) begin
      start = tv[i].start; ack = tv[i].ack; pcl = tv[i].pcl; pcv = tv[i].pcv;
      tick;
      chk($sformatf("vec%0d_rd", i), rd, tv[i].rd);
      if (tv[i].rd) chk($sformatf("vec%0d_addr", i), addr, tv[i].addr);
      chk($sformatf("vec%0d_pc", i), pc, tv[i].pc);
      chk($sformatf("vec%0d_valid", i), valid, tv[i].valid);
      if (tv[i].valid) chk($sformatf("vec%0d_ir", i), ir, tv[i].ir);
    end
    start = 1'b0; ack = 1'b0; pcl = 1'b0;
    // wrap: PcLoad beats Start in IDLE, fetch then starts on the next edge
    mem[16'hFFFF] = 8'h78; mem[0] = 8'h56;
    pcl = 1'b1; pcv = 16'hFFFF; start = 1'b1;
    tick; pcl = 1'b0;
    chk("wrap_load_rd", rd, 0);
    chk("wrap_load_pc", pc, 16'hFFFF);
    tick;
    chk("wrap_rd_lo", rd, 1);
    chk("wrap_addr_lo", addr, 16'hFFFF);
    tick; tick;
    chk("wrap_rd_hi", rd, 1);
    chk("wrap_addr_hi", addr, 16'h0000);
    tick; tick;
    chk("wrap_valid", valid, 1);
    chk("wrap_ir", ir, 16'h5678);
    chk("wrap_pc", pc, 16'h0001);
    start = 1'b0; ack = 1'b1;
    tick; ack = 1'b0;
    chk("wrap_ack_valid", valid, 0);
    // flush during WAIT_HI
    start = 1'b1;
    tick; start = 1'b0;
    tick; tick; tick;
    chk("flush_pre_pc", pc, 16'h0002);
    pcl = 1'b1; pcv = 16'h0100;
    tick; pcl = 1'b0;
    chk("flush_valid", valid, 0);
    chk("flush_rd", rd, 0);
    chk("flush_pc", pc, 16'h0100);
    chk("flush_ir_hi", ir[15:8], 8'h56);
    tick;
    chk("flush_idle_pc", pc, 16'h0100);
    chk("flush_idle_valid", valid, 0);
    mem[16'h0100] = 8'hEF; mem[16'h0101] = 8'hBE;
    start = 1'b1;
    tick; start = 1'b0;
    chk("flush_next_addr", addr, 16'h0100);
    tick; tick; tick; tick;
    chk("flush_next_valid", valid, 1);
    chk("flush_next_ir", ir, 16'hBEEF);
    chk("flush_next_pc", pc, 16'h0102);
    // random phase against a transaction-level model
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    #2 rst_n = 1'b0;
    tick; rst_n = 1'b1;
    m_pc = 16'h0000; m_ir = '0; m_valid = 1'b0; m_busy = 1'b0; m_t = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom % 4) != 0;
      ack = ($urandom % 3) == 0;
      pcl = ($urandom % 20) == 0;
      pcv = 16'($urandom);
      if ($urandom % 3 == 0) pcv = 16'hFFFF - 16'($urandom % 3);
      if (pcl) begin
        m_pc = pcv; m_valid = 1'b0; m_busy = 1'b0;
      end else if (m_valid) begin
        if (ack) begin
          m_valid = 1'b0; m_busy = start; m_t = 0;
        end
      end else if (m_busy) begin
        m_t++;
        if (m_t == 1 + L1) begin
          m_ir[7:0] = mem[m_pc]; m_pc++;
        end else if (m_t == 2 * (1 + L1)) begin
          m_ir[15:8] = mem[m_pc]; m_pc++; m_valid = 1'b1; m_busy = 1'b0;
        end
      end else if (start) begin
        m_busy = 1'b1; m_t = 0;
      end
      tick;
      chk("rnd_rd", rd, 32'(m_busy && (m_t == 0 || m_t == 1 + L1)));
      if (m_busy && (m_t == 0 || m_t == 1 + L1)) chk("rnd_addr", addr, m_pc);
      chk("rnd_pc", pc, m_pc);
      chk("rnd_valid", valid, m_valid);
      if (m_valid) chk("rnd_ir", ir, m_ir);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
